// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 4;
  localparam int unsigned FIFO_DEF_DEPTH = 4;

  // Bits needed to address DEPTH entries (pointers wrap naturally).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Bits needed to hold an occupancy of 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_sync_param: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and one-cycle overflow/underflow pulses.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through
// output; when undefined, dout is a registered read with one cycle latency.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic [WIDTH-1:0]            din,
  input  logic                        write,
  input  logic                        read,
  output logic [WIDTH-1:0]            dout,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Accept logic: a write into a full FIFO is allowed only when a read
  // frees the slot on the same edge.
  always_comb begin
    rd_acc = read & ~empty_q;
    wr_acc = write & (~full_q | rd_acc);
  end

  // Next-state for pointers, occupancy, registered flags and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d        = (count_d == '0);
    full_d         = (32'(count_d) == DEPTH);
    almost_full_d  = (32'(count_d) >= AF_LEVEL);
    almost_empty_d = (32'(count_d) <= AE_LEVEL);
    overflow_d     = write & ~wr_acc;
    underflow_d    = read & empty_q;
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= (AF_LEVEL == 0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; forced to zero so stale memory never shows.
  assign dout = empty_q ? '0 : mem_rdata;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Registered read: load the head word on an accepted read, hold otherwise.
  always_comb begin
    dout_d = dout_q;
    if (rd_acc) begin
      dout_d = mem_rdata;
    end
  end

  // Output data register, cleared with the control state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (WIDTH=4, DEPTH=4, default levels),
// checked against a queue scoreboard. Works with or without FIFO_FWFT_EN.
module tb_fifo_sync_param;

  logic       clk;
  logic       clr_n;
  logic [3:0] din;
  logic       write;
  logic       read;
  logic [3:0] dout;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  logic [3:0] sb[$];
  logic [3:0] hold_dout;

  fifo_sync_param #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .din          (din),
    .write        (write),
    .read         (read),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard-derived expectation.
  task automatic check_all(input string step_tag, input logic exp_ov, input logic exp_un);
    int         n;
    logic [3:0] exp_dout;
    n = sb.size();
`ifdef FIFO_FWFT_EN
    exp_dout = (n > 0) ? sb[0] : 4'h0;
`else
    exp_dout = hold_dout;
`endif
    chk({step_tag, ".count"}, 32'(count), 32'(n));
    chk({step_tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({step_tag, ".full"}, 32'(full), 32'(n == 4));
    chk({step_tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
    chk({step_tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    chk({step_tag, ".overflow"}, 32'(overflow), 32'(exp_ov));
    chk({step_tag, ".underflow"}, 32'(underflow), 32'(exp_un));
    chk({step_tag, ".dout"}, 32'(dout), 32'(exp_dout));
    $display("step %-10s wr=%0d rd=%0d din=%h -> count=%0d empty=%0d full=%0d af=%0d ae=%0d ovf=%0d udf=%0d dout=%h",
             step_tag, write, read, din, count, empty, full, almost_full, almost_empty,
             overflow, underflow, dout);
  endtask

  // One clock: drive at negedge, predict, clock, compare at the next negedge.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [3:0] d);
    logic       rd_ok, wr_ok, exp_ov, exp_un;
    logic [3:0] popped;
    int         n;
    n      = sb.size();
    rd_ok  = rd && (n > 0);
    wr_ok  = wr && ((n < 4) || rd_ok);
    exp_ov = wr && !wr_ok;
    exp_un = rd && (n == 0);
    write = wr;
    read  = rd;
    din   = d;
    @(posedge clk);
    @(negedge clk);
    if (rd_ok) begin
      popped    = sb.pop_front();
      hold_dout = popped;
    end
    if (wr_ok) sb.push_back(d);
    check_all(tag, exp_ov, exp_un);
    write = 1'b0;
    read  = 1'b0;
  endtask

  // Asynchronous clear: effect is checked before any clock edge occurs.
  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    #1;
    sb.delete();
    hold_dout = 4'h0;
    check_all(tag, 1'b0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n     = 1'b0;
    write     = 1'b0;
    read      = 1'b0;
    din       = 4'h0;
    hold_dout = 4'h0;
    @(negedge clk);
    do_reset("rst_init");

    // Reset mid-fill, then read from the cleared FIFO.
    step("wr_3", 1'b1, 1'b0, 4'h3);
    step("wr_5", 1'b1, 1'b0, 4'h5);
    do_reset("rst_mid");
    step("rd_udf", 1'b0, 1'b1, 4'h0);

    // Fill to full, then overflow once.
    step("fill_1", 1'b1, 1'b0, 4'h1);
    step("fill_2", 1'b1, 1'b0, 4'h2);
    step("fill_3", 1'b1, 1'b0, 4'h3);
    step("fill_4", 1'b1, 1'b0, 4'h4);
    step("wr_ovf", 1'b1, 1'b0, 4'hF);
    step("idle", 1'b0, 1'b0, 4'h0);

    // Drain in order, then back-to-back refused reads.
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 4'h0);
    step("udf_a", 1'b0, 1'b1, 4'h0);
    step("udf_b", 1'b0, 1'b1, 4'h0);
    step("idle", 1'b0, 1'b0, 4'h0);

    // Simultaneous read+write while full.
    for (int i = 1; i <= 4; i++) step("refill", 1'b1, 1'b0, 4'(i));
    step("rw_full", 1'b1, 1'b1, 4'h9);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 1'b1, 4'h0);

    // Simultaneous read+write while empty.
    step("rw_empty", 1'b1, 1'b1, 4'h7);
    step("rd_7", 1'b0, 1'b1, 4'h0);

    // Alternating write/read across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step("wrap_wr", 1'b1, 1'b0, 4'(i));
      step("wrap_rd", 1'b0, 1'b1, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO; the next generation of the team's 4-deep, 4-bit latch-chain FIFO. It replaces the ripple RS-latch control with pointer and counter logic on a single clock. It adds configurable width and depth, occupancy count, almost-full/almost-empty thresholds, and overflow/underflow error pulses. It sits between producer and consumer stages of the lab datapath wherever rate decoupling is needed.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count ≤ AE_LEVEL
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- din  input  WIDTH  write data
- write  input  1  write request, sampled at rising clk
- read  input  1  read request, sampled at rising clk
- dout  output  WIDTH  read data
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  one-cycle pulse: write refused
- underflow  output  1  one-cycle pulse: read refused

## Operation
- Storage is DEPTH × WIDTH. Write pointer and read pointer are $clog2(DEPTH) bits each and wrap naturally from DEPTH-1 to 0. A separate count register tracks occupancy.
- Write is accepted when write=1 and either full=0, or full=1 and an accepted read happens in the same cycle. An accepted write stores din at mem[wr_ptr] and increments wr_ptr.
- Read is accepted when read=1 and empty=0. An accepted read increments rd_ptr.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Refused write (write=1, full=1, no accepted read): memory and pointers are unchanged, and overflow=1 for the next cycle.
- Refused read (read=1, empty=1): underflow=1 for the next cycle. A write in the same cycle is still accepted, so count becomes 1.
- Status flags and count are registered and reflect the state after the edge.
- Reset (clr_n=0, any time, including mid-transfer):
  - pointers and count go to 0
  - empty=1, full=0, almost_empty=1
  - almost_full=(AF_LEVEL==0)
  - overflow=underflow=0, dout=0
  - memory contents are not reset; stale data is never visible because empty=1.
- Reset release is synchronous to clk. The first edge with clr_n=1 may accept a write.

## Timing
- Write-to-visible latency: an accepted write at edge N sets empty=0 after edge N. Data is readable from then on.
- dout behaviour depends on FIFO_FWFT_EN (see Configuration).
- Error pulses are exactly one cycle per refused request. Back-to-back refusals keep the pulse high continuously.
- The DEPTH-th write sets full=1 after that edge. Reading the last entry sets empty=1 after that edge.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through.
  - dout = mem[rd_ptr] combinationally whenever empty=0, and dout=0 while empty=1.
  - An accepted read pops the shown word; the next word appears after the edge.
- FIFO_FWFT_EN undefined: registered read.
  - On an accepted read at edge N, dout loads mem[rd_ptr] and is valid from N until the next accepted read.
  - dout holds its value otherwise, including when empty. Read latency is 1 cycle.

## Structure
- Package fifo_pkg holds:
  - the pointer-width and count-width helper (clog2-based)
  - the default parameter constants (WIDTH=4, DEPTH=4).
- Sub-module fifo_mem holds the register array: one synchronous write port and one asynchronous read port, with no reset. fifo_sync_param instantiates it once and keeps all control logic.

## Test plan
All scenarios use WIDTH=4, DEPTH=4, default levels.
- Reset mid-fill: write 0x3, 0x5, assert clr_n=0 for 1 cycle → count=0, empty=1, dout=0. A subsequent read gives underflow=1 and no data.
- Fill to full: write 0x1, 0x2, 0x3, 0x4.
  - After the third write: almost_full=1, count=3.
  - After the fourth: full=1, count=4.
  - A fifth write of 0xF gives overflow=1 for 1 cycle, and count stays 4.
- Drain in order: from full, read 4 times → dout sequence 0x1, 0x2, 0x3, 0x4 (FWFT: before each pop; registered: one cycle after each read). empty=1 after the last read, and almost_empty=1 once count ≤ 1.
- Simultaneous read+write at full: full with 0x1..0x4, then read=write=1 with din=0x9 → count stays 4, full stays 1, no overflow. The drain order is then 0x2, 0x3, 0x4, 0x9.
- Simultaneous read+write at empty: read=write=1 with din=0x7 → underflow=1, count=1, and 0x7 is readable next.
- Wrap-around: 10 alternating write/read pairs with data 0x0..0x9 → every word is read back in order across pointer wrap, with count never exceeding 1 and no error pulses.
